// File: rtl/vec_ex_operand_stage.sv
// vec_ex_operand_stage: ID/EX register for the vector pipe.
// Latches decoded operands into EX, tracks destination registers in EX and
// MEM, registers the 3:1 forward selects for the EX operand muxes and holds
// decode off on hazards.
// Build option: define VEC_FORWARD_EN for forwarding with a one-bubble
// load-use stall; without it, selects are tied to 00 and ID waits for every
// RAW producer to reach WB.

// Per-lane operand register: loads both sources when an instruction is
// accepted, otherwise holds.
module vec_ex_lane #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [N-1:0] rda,
  input  logic [N-1:0] rdb,
  output logic [N-1:0] qa,
  output logic [N-1:0] qb
);
  // operand capture, held through bubbles and stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      qa <= '0;
      qb <= '0;
    end else if (ld) begin
      qa <= rda;
      qb <= rdb;
    end
endmodule

module vec_ex_operand_stage #(
  parameter int N = 16,
  parameter int M = 16,
  parameter int R = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  output logic           id_ready,
  input  logic [R-1:0]   id_vra,
  input  logic [R-1:0]   id_vrb,
  input  logic [R-1:0]   id_vrd,
  input  logic           id_we,
  input  logic           id_is_load,
  input  logic [M*N-1:0] id_rda,
  input  logic [M*N-1:0] id_rdb,
  input  logic           stall_in,
  input  logic           flush,
  output logic           ex_valid,
  output logic [M*N-1:0] ex_rda,
  output logic [M*N-1:0] ex_rdb,
  output logic [R-1:0]   ex_vrd,
  output logic           ex_we,
  output logic           ex_is_load,
  output logic [1:0]     ex_sel_a,
  output logic [1:0]     ex_sel_b
);
  typedef struct packed {
    logic [R-1:0] vrd;
    logic         we;
  } trk_t;

  // vld_pipe[0] = EX, vld_pipe[1] = MEM. The WB slot carries no state here:
  // nothing reads it, since the register file write-through covers WB.
  logic [1:0] vld_pipe;
  trk_t       ex_t, mem_t;
  logic       ex_ld;
  logic       hz, acc;
  logic [1:0] nxt_sel_a, nxt_sel_b;

  logic [M-1:0][N-1:0] rda_l, rdb_l, qa_l, qb_l;

  assign rda_l = id_rda;
  assign rdb_l = id_rdb;
  assign ex_rda = qa_l;
  assign ex_rdb = qb_l;

`ifdef VEC_FORWARD_EN
  // only a load in EX cannot be forwarded in time
  assign hz = id_valid & vld_pipe[0] & ex_ld & ex_t.we &
              ((ex_t.vrd == id_vra) | (ex_t.vrd == id_vrb));

  // nearest producer wins: EX result (01) over MEM result (10)
  always_comb begin
    nxt_sel_a = 2'b00;
    nxt_sel_b = 2'b00;
    if (vld_pipe[0] & ex_t.we & (ex_t.vrd == id_vra))        nxt_sel_a = 2'b01;
    else if (vld_pipe[1] & mem_t.we & (mem_t.vrd == id_vra)) nxt_sel_a = 2'b10;
    if (vld_pipe[0] & ex_t.we & (ex_t.vrd == id_vrb))        nxt_sel_b = 2'b01;
    else if (vld_pipe[1] & mem_t.we & (mem_t.vrd == id_vrb)) nxt_sel_b = 2'b10;
  end
`else
  logic raw_ex, raw_mem;

  // no forwarding: any in-flight writer of a source blocks decode
  always_comb begin
    raw_ex  = vld_pipe[0] & ex_t.we & ((ex_t.vrd == id_vra) | (ex_t.vrd == id_vrb));
    raw_mem = vld_pipe[1] & mem_t.we & ((mem_t.vrd == id_vra) | (mem_t.vrd == id_vrb));
    hz      = id_valid & (raw_ex | raw_mem);
  end

  assign nxt_sel_a = 2'b00;
  assign nxt_sel_b = 2'b00;
`endif

  assign id_ready = rst_n & ~stall_in & ~hz;
  assign acc      = id_valid & id_ready & ~flush;

  // slot tracking and select registers; everything freezes under stall_in
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      ex_t     <= '0;
      mem_t    <= '0;
      ex_ld    <= 1'b0;
      ex_sel_a <= 2'b00;
      ex_sel_b <= 2'b00;
    end else if (!stall_in) begin
      vld_pipe <= {vld_pipe[0], acc};
      mem_t    <= ex_t;
      ex_t.we  <= acc & id_we;
      ex_ld    <= acc & id_is_load;
      if (acc) ex_t.vrd <= id_vrd;
      ex_sel_a <= acc ? nxt_sel_a : 2'b00;
      ex_sel_b <= acc ? nxt_sel_b : 2'b00;
    end

  for (genvar i = 0; i < M; i++) begin : g_lane
    vec_ex_lane #(.N(N)) u_lane (
      .clk (clk),
      .rst_n (rst_n),
      .ld  (acc),
      .rda (rda_l[i]),
      .rdb (rdb_l[i]),
      .qa  (qa_l[i]),
      .qb  (qb_l[i])
    );
  end

  assign ex_valid   = vld_pipe[0];
  assign ex_vrd     = ex_t.vrd;
  assign ex_we      = vld_pipe[0] & ex_t.we;
  assign ex_is_load = vld_pipe[0] & ex_ld;
endmodule
